multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Moore-style control FSM for the multi-cycle MIPS datapath. Sequences one instruction over 3–5 states (plus memory wait cycles) and drives every datapath select and enable: PC, instruction register, memory, register file and ALU. It replaces the single-cycle opcode decoder for R-type, lw, sw, beq, j and jal. The shared instruction/data memory is accessed through a ready handshake.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- op_code  in  6  opcode from instruction register (stable from DECODE until next FETCH completes)
- mem_ready  in  1  memory completes current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (gated in datapath)
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC (already PC+4)
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 PC, 1 reg A
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  2  00 use funct, 01 add, 11 subtract
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- illegal_op  out  1  one-cycle pulse: unsupported opcode decoded
- state  out  4  current state encoding (debug/verification)

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, JAL 10. Encodings 11–15 are unreachable and go to FETCH next cycle with all outputs 0.
- Outputs per state (any output not listed is 0; outputs are never driven x):
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=01, ir_write=pc_write=mem_ready, pc_source=00.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=01 (branch target into ALUOut).
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=01.
  - MEM_READ: mem_read=1, i_or_d=1.
  - MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01.
  - MEM_WRITE: mem_write=1, i_or_d=1.
  - R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=00.
  - R_WB: reg_write=1, reg_dst=01, mem_to_reg=00.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=11, pc_write_cond=1, pc_source=01.
  - JUMP: pc_write=1, pc_source=10.
  - JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10.
- Transitions:
  - FETCH→DECODE when mem_ready=1; otherwise stay in FETCH.
  - DECODE: 000000→R_EXEC; 100011 or 101011→MEM_ADDR; 000100→BRANCH; 000010→JUMP; 000011→JAL; any other opcode→FETCH with illegal_op=1 in that DECODE cycle and no write enables.
  - MEM_ADDR: 100011→MEM_READ, 101011→MEM_WRITE.
  - MEM_READ→MEM_WB and MEM_WRITE→FETCH, each only when mem_ready=1; otherwise hold.
  - MEM_WB, R_EXEC→R_WB, R_WB, BRANCH, JUMP and JAL each advance unconditionally. MEM_WB, R_WB, BRANCH, JUMP and JAL all go to FETCH.

## Timing
- While rst=1: state=FETCH (0) and all outputs forced 0, including mem_read. First FETCH request is the first cycle after rst deasserts.
- Reset mid-instruction aborts immediately: no write enable stays asserted after rst rises, and the partial instruction is discarded.
- Cycles per instruction with mem_ready always 1: lw 5, sw 4, R-type 4, beq 3, j 3, jal 3, illegal 2. Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle and holds all outputs unchanged.
- ir_write and pc_write in FETCH assert only in the mem_ready=1 cycle, exactly once per fetch.
- mem_read and mem_write are never asserted together. Write enables (reg_write, mem_write, pc_write, ir_write, pc_write_cond) are asserted for exactly one accepted cycle per instruction step.

## Test plan
- Reset then lw (op 100011), mem_ready=1: state sequence 0,1,2,3,4,0. reg_write=1 with mem_to_reg=01 in state 4 only.
- sw (101011) with mem_ready low for 3 cycles in MEM_WRITE: state holds at 5 with mem_write=1 for 4 cycles, then returns to 0. reg_write=0 throughout.
- R-type, beq and jal back to back: sequences 0,1,6,7 / 0,1,8 / 0,1,10. In state 10: reg_dst=10, mem_to_reg=10, pc_source=10.
- Fetch stall, mem_ready=0 for 2 cycles: ir_write=0 for 2 cycles, then ir_write=pc_write=1 for exactly 1 cycle.
- Illegal opcode 111111: illegal_op=1 for one cycle in state 1, then state 0. No write enable asserted in between.
- rst pulse during MEM_READ: all outputs 0 in the same cycle, state=0. After release, a fresh fetch runs with pc_write asserted once.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM sequencing one MIPS instruction over the multi-cycle datapath.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op_code,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3,
        MEM_WB = 4'd4, MEM_WRITE = 4'd5, R_EXEC = 4'd6, R_WB = 4'd7,
        BRANCH = 4'd8, JUMP = 4'd9, JAL = 4'd10
    } state_e;
    state_e state_q, state_d;
    logic is_r, is_lw, is_sw, is_beq, is_j, is_jal;
    assign is_r   = op_code == 6'b000000;
    assign is_lw  = op_code == 6'b100011;
    assign is_sw  = op_code == 6'b101011;
    assign is_beq = op_code == 6'b000100;
    assign is_j   = op_code == 6'b000010;
    assign is_jal = op_code == 6'b000011;
    assign state  = state_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:     state_d = mem_ready ? DECODE : FETCH;
            DECODE:    state_d = is_r ? R_EXEC : (is_lw || is_sw) ? MEM_ADDR : is_beq ? BRANCH :
                                 is_j ? JUMP : is_jal ? JAL : FETCH;
            MEM_ADDR:  state_d = is_lw ? MEM_READ : is_sw ? MEM_WRITE : FETCH;
            MEM_READ:  state_d = mem_ready ? MEM_WB : MEM_READ;
            MEM_WRITE: state_d = mem_ready ? FETCH : MEM_WRITE;
            R_EXEC:    state_d = R_WB;
            default:   state_d = FETCH;
        endcase
    end
    // Outputs are decoded from the state but masked by rst so a reset aborts in the same cycle.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    alu_src_b  = 2'b11;
                    alu_op     = 2'b01;
                    illegal_op = !(is_r || is_lw || is_sw || is_beq || is_j || is_jal);
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b01;
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                end
                MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                R_EXEC: alu_src_a = 1'b1;
                R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 2'b01;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b11;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                JAL: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed checks of state sequence and per-state control outputs.
module tb_multicycle_controller;
    logic       clk = 1'b0, rst = 1'b1, mem_ready = 1'b0;
    logic [5:0] op_code = 6'd0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write, alu_src_a, illegal_op;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    int passed = 0, total = 0;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
                           J = 6'b000010, JAL = 6'b000011, BAD = 6'b111111;
    // {pc_write,pc_write_cond,i_or_d,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_op,pc_source,illegal_op}
    localparam logic [18:0] V_ZERO   = '0;
    localparam logic [18:0] V_FETCH  = 19'b1_0_0_1_0_1_00_00_0_0_01_01_00_0;
    localparam logic [18:0] V_STALL  = 19'b0_0_0_1_0_0_00_00_0_0_01_01_00_0;
    localparam logic [18:0] V_DEC    = 19'b0_0_0_0_0_0_00_00_0_0_11_01_00_0;
    localparam logic [18:0] V_ILL    = 19'b0_0_0_0_0_0_00_00_0_0_11_01_00_1;
    localparam logic [18:0] V_MADDR  = 19'b0_0_0_0_0_0_00_00_0_1_10_01_00_0;
    localparam logic [18:0] V_MREAD  = 19'b0_0_1_1_0_0_00_00_0_0_00_00_00_0;
    localparam logic [18:0] V_MWB    = 19'b0_0_0_0_0_0_00_01_1_0_00_00_00_0;
    localparam logic [18:0] V_MWRITE = 19'b0_0_1_0_1_0_00_00_0_0_00_00_00_0;
    localparam logic [18:0] V_REXEC  = 19'b0_0_0_0_0_0_00_00_0_1_00_00_00_0;
    localparam logic [18:0] V_RWB    = 19'b0_0_0_0_0_0_01_00_1_0_00_00_00_0;
    localparam logic [18:0] V_BR     = 19'b0_1_0_0_0_0_00_00_0_1_00_11_01_0;
    localparam logic [18:0] V_JUMP   = 19'b1_0_0_0_0_0_00_00_0_0_00_00_10_0;
    localparam logic [18:0] V_JAL    = 19'b1_0_0_0_0_0_10_10_1_0_00_00_10_0;
    logic [18:0] outs;
    assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                   reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
    multicycle_controller dut (
        .clk(clk), .rst(rst), .op_code(op_code), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [3:0] st, input logic [18:0] v);
        total++;
        assert (state === st) passed++;
        else $error("FAIL %s state: observed %0d expected %0d", tag, state, st);
        total++;
        assert (outs === v) passed++;
        else $error("FAIL %s outputs: observed %b expected %b", tag, outs, v);
    endtask
    // Drive inputs just after the rising edge, check at the falling edge, then advance.
    task automatic step(input logic mr, input logic [5:0] op, input string tag, input logic [3:0] st, input logic [18:0] v);
        mem_ready = mr;
        op_code = op;
        @(negedge clk);
        chk(tag, st, v);
        @(posedge clk);
        #1;
    endtask
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b1;
        chk("reset", 4'd0, V_ZERO);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1, LW, "lw_fetch", 4'd0, V_FETCH);
        step(1, LW, "lw_dec", 4'd1, V_DEC);
        step(1, LW, "lw_addr", 4'd2, V_MADDR);
        step(1, LW, "lw_read", 4'd3, V_MREAD);
        step(1, LW, "lw_wb", 4'd4, V_MWB);
        step(1, SW, "sw_fetch", 4'd0, V_FETCH);
        step(1, SW, "sw_dec", 4'd1, V_DEC);
        step(1, SW, "sw_addr", 4'd2, V_MADDR);
        step(0, SW, "sw_wait0", 4'd5, V_MWRITE);
        step(0, SW, "sw_wait1", 4'd5, V_MWRITE);
        step(0, SW, "sw_wait2", 4'd5, V_MWRITE);
        step(1, SW, "sw_write", 4'd5, V_MWRITE);
        step(1, RT, "r_fetch", 4'd0, V_FETCH);
        step(1, RT, "r_dec", 4'd1, V_DEC);
        step(1, RT, "r_exec", 4'd6, V_REXEC);
        step(1, RT, "r_wb", 4'd7, V_RWB);
        step(1, BEQ, "beq_fetch", 4'd0, V_FETCH);
        step(1, BEQ, "beq_dec", 4'd1, V_DEC);
        step(1, BEQ, "beq_br", 4'd8, V_BR);
        step(1, JAL, "jal_fetch", 4'd0, V_FETCH);
        step(1, JAL, "jal_dec", 4'd1, V_DEC);
        step(1, JAL, "jal_jal", 4'd10, V_JAL);
        step(1, J, "j_fetch", 4'd0, V_FETCH);
        step(1, J, "j_dec", 4'd1, V_DEC);
        step(1, J, "j_jump", 4'd9, V_JUMP);
        step(0, RT, "stall0", 4'd0, V_STALL);
        step(0, RT, "stall1", 4'd0, V_STALL);
        step(1, RT, "stall_done", 4'd0, V_FETCH);
        step(1, RT, "stall_dec", 4'd1, V_DEC);
        step(1, RT, "stall_exec", 4'd6, V_REXEC);
        step(1, RT, "stall_wb", 4'd7, V_RWB);
        step(1, BAD, "ill_fetch", 4'd0, V_FETCH);
        step(1, BAD, "ill_dec", 4'd1, V_ILL);
        step(1, BAD, "ill_next", 4'd0, V_FETCH);
        step(1, LW, "rlw_dec", 4'd1, V_DEC);
        step(1, LW, "rlw_addr", 4'd2, V_MADDR);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("rlw_read", 4'd3, V_MREAD);
        #2 rst = 1'b1;
        #1 chk("rst_abort", 4'd0, V_ZERO);
        @(posedge clk);
        #1 chk("rst_hold", 4'd0, V_ZERO);
        rst = 1'b0;
        step(1, RT, "post_fetch", 4'd0, V_FETCH);
        step(1, RT, "post_dec", 4'd1, V_DEC);
        step(1, RT, "post_exec", 4'd6, V_REXEC);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
